// File: rtl/uart_mem_pkg.sv
// Shared constants, state encoding and status bit positions for the UART memory bridge.
// Checksum framing is compiled in with UART_MEM_BRIDGE_CKSUM_EN.
package uart_mem_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD  = 8'h3F;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam int STS_DONE = 0;
    localparam int STS_BAD  = 1;
    localparam int STS_TMO  = 2;
    localparam int STS_OVR  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
`ifdef UART_MEM_BRIDGE_CKSUM_EN
        ST_CKSUM,
`endif
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_RESP
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte idle counter; pulses o_expire on the TIMEOUT_CYCLES-th idle cycle while enabled.
// TIMEOUT_CYCLES = 0 removes the counter entirely.
module uart_frame_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused = ^{clk, rst, i_clear, i_enable};
            assign o_expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_cnt <= '0;
                else if (i_clear || !i_enable)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + CW'(1);
            end

            // Fires during the last allowed idle cycle so the FSM leaves on the following edge.
            assign o_expire = i_enable && !i_clear && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/uart_mem_bridge.sv
// UART byte-stream command engine: 'W'/'R' frames become single-word memory accesses with a byte response.
// Optional trailing XOR checksum on frames and responses via UART_MEM_BRIDGE_CKSUM_EN.
module uart_mem_bridge
    import uart_mem_pkg::*;
#(
    parameter int ADDR_BYTES     = 2,
    parameter int DATA_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_byte,
    input  logic                    rx_valid,
    output logic [7:0]              tx_byte,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [8*ADDR_BYTES-1:0] mem_addr,
    output logic [8*DATA_BYTES-1:0] mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rvalid,
    input  logic [8*DATA_BYTES-1:0] mem_rdata,
    input  logic                    sts_clr,
    output logic [3:0]              status,
    output logic                    busy
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
    localparam int     CK_BYTES     = 1;
    localparam state_t ST_FRAME_END = ST_CKSUM;
`else
    localparam int     CK_BYTES     = 0;
    localparam state_t ST_FRAME_END = ST_MEM_REQ;
`endif
    localparam int RESP_MAX = DATA_BYTES + CK_BYTES;
    localparam int IW       = (RESP_MAX > 1) ? $clog2(RESP_MAX) : 1;

    typedef logic [RESP_MAX-1:0][7:0] resp_t;

    state_t          r_state, w_next;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_we;
    logic [2:0]      r_cnt;
    resp_t           r_resp;
    logic [IW-1:0]   r_idx, r_last;
    logic            r_done_ok;
    logic [3:0]      r_status;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
    logic [7:0]      r_cksum;
    logic            w_ck_ok;
`endif

    logic            w_expire, w_in_frame, w_last_field, w_op_ok;
    logic            w_tx_hs, w_resp_end;
    logic            w_load, w_load_ok;
    resp_t           w_load_buf;
    logic [IW-1:0]   w_load_last;
    logic [7:0]      w_rd_x;
    logic [3:0]      w_sts_set;

    // Control-byte responses carry a copy of themselves as checksum (XOR of one byte).
    function automatic resp_t single_resp(input logic [7:0] b);
        resp_t r;
        r    = '0;
        r[0] = b;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
        r[1] = b;
`endif
        return r;
    endfunction

`ifdef UART_MEM_BRIDGE_CKSUM_EN
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CKSUM);
    assign w_ck_ok    = (rx_byte == r_cksum);
`else
    assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_DATA);
`endif
    assign w_op_ok      = is_opcode(rx_byte);
    assign w_last_field = (r_state == ST_ADDR) ? (r_cnt == 3'(ADDR_BYTES - 1))
                                               : (r_cnt == 3'(DATA_BYTES - 1));
    assign w_tx_hs      = (r_state == ST_RESP) && tx_ready;
    assign w_resp_end   = w_tx_hs && (r_idx == r_last);

    uart_frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (rx_valid),
        .i_enable(w_in_frame),
        .o_expire(w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (rx_valid) w_next = w_op_ok ? ST_ADDR : ST_RESP;
            ST_ADDR: begin
                if (w_expire)                      w_next = ST_IDLE;
                else if (rx_valid && w_last_field) w_next = r_we ? ST_DATA : ST_FRAME_END;
            end
            ST_DATA: begin
                if (w_expire)                      w_next = ST_IDLE;
                else if (rx_valid && w_last_field) w_next = ST_FRAME_END;
            end
`ifdef UART_MEM_BRIDGE_CKSUM_EN
            ST_CKSUM: begin
                if (w_expire)      w_next = ST_IDLE;
                else if (rx_valid) w_next = w_ck_ok ? ST_MEM_REQ : ST_RESP;
            end
`endif
            ST_MEM_REQ:  if (mem_ready)  w_next = r_we ? ST_RESP : ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_rvalid) w_next = ST_RESP;
            ST_RESP:     if (w_resp_end) w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Response buffer contents chosen on the cycle that enters RESP.
    always_comb begin
        w_load      = 1'b0;
        w_load_ok   = 1'b0;
        w_load_buf  = '0;
        w_load_last = '0;
        w_rd_x      = '0;
        case (r_state)
            ST_IDLE: if (rx_valid && !w_op_ok) begin
                w_load      = 1'b1;
                w_load_buf  = single_resp(RSP_BAD);
                w_load_last = IW'(CK_BYTES);
            end
`ifdef UART_MEM_BRIDGE_CKSUM_EN
            ST_CKSUM: if (rx_valid && !w_ck_ok) begin
                w_load      = 1'b1;
                w_load_buf  = single_resp(RSP_ERR);
                w_load_last = IW'(CK_BYTES);
            end
`endif
            ST_MEM_REQ: if (mem_ready && r_we) begin
                w_load      = 1'b1;
                w_load_ok   = 1'b1;
                w_load_buf  = single_resp(RSP_OK);
                w_load_last = IW'(CK_BYTES);
            end
            ST_MEM_WAIT: if (mem_rvalid) begin
                w_load      = 1'b1;
                w_load_ok   = 1'b1;
                w_load_last = IW'(RESP_MAX - 1);
                for (int i = 0; i < DATA_BYTES; i++) begin
                    w_load_buf[i] = mem_rdata[8*(DATA_BYTES-1-i) +: 8];
                    w_rd_x        = w_rd_x ^ mem_rdata[8*(DATA_BYTES-1-i) +: 8];
                end
`ifdef UART_MEM_BRIDGE_CKSUM_EN
                w_load_buf[DATA_BYTES] = w_rd_x;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        w_sts_set           = '0;
        w_sts_set[STS_DONE] = w_resp_end && r_done_ok;
        w_sts_set[STS_BAD]  = w_load && !w_load_ok;
        w_sts_set[STS_TMO]  = w_expire;
        w_sts_set[STS_OVR]  = rx_valid && ((r_state == ST_MEM_REQ) || (r_state == ST_MEM_WAIT)
                                           || (r_state == ST_RESP));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_cnt     <= '0;
            r_resp    <= '0;
            r_idx     <= '0;
            r_last    <= '0;
            r_done_ok <= 1'b0;
            r_status  <= '0;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
            r_cksum   <= '0;
`endif
        end else begin
            r_status <= (sts_clr ? 4'b0000 : r_status) | w_sts_set;

            if (w_load) begin
                r_resp    <= w_load_buf;
                r_last    <= w_load_last;
                r_done_ok <= w_load_ok;
                r_idx     <= '0;
            end else if (w_tx_hs) begin
                r_idx <= w_resp_end ? '0 : r_idx + IW'(1);
            end

            if (rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        r_we  <= (rx_byte == OP_WRITE);
                        r_cnt <= '0;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
                        r_cksum <= rx_byte;
`endif
                    end
                    ST_ADDR: begin
                        r_addr <= (r_addr << 8) | AW'(rx_byte);
                        r_cnt  <= w_last_field ? 3'd0 : r_cnt + 3'd1;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_byte;
`endif
                    end
                    ST_DATA: begin
                        r_wdata <= (r_wdata << 8) | DW'(rx_byte);
                        r_cnt   <= w_last_field ? 3'd0 : r_cnt + 3'd1;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
                        r_cksum <= r_cksum ^ rx_byte;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tx_valid  = (r_state == ST_RESP);
        tx_byte   = tx_valid ? r_resp[r_idx] : 8'h00;
        mem_req   = (r_state == ST_MEM_REQ);
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        busy      = (r_state != ST_IDLE);
        status    = r_status;
    end

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed scoreboard bench for uart_mem_bridge (TIMEOUT_CYCLES=16); follows UART_MEM_BRIDGE_CKSUM_EN if defined.
module tb_uart_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sts_clr;
    logic [3:0]  status;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_tx[$];
    logic [48:0] exp_req[$];
    logic [7:0]  frame[$];
    logic [31:0] rd_value = 32'h0;
`ifdef UART_MEM_BRIDGE_CKSUM_EN
    logic [7:0]  ck_corrupt = 8'h00;
`endif

    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [7:0]  prev_b = 8'h00;

    uart_mem_bridge #(
        .ADDR_BYTES    (2),
        .DATA_BYTES    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .sts_clr   (sts_clr),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // TX scoreboard plus hold-under-backpressure check.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && prev_v && !prev_r)
                check("tx_hold", 64'(tx_byte), 64'(prev_b));
            if (tx_valid && tx_ready) begin
                total++;
                assert (exp_tx.size() > 0) else begin
                    bad++;
                    $error("FAIL tx_extra observed=%0h expected=none", tx_byte);
                end
                if (exp_tx.size() > 0)
                    check("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
            end
        end
        prev_v <= tx_valid;
        prev_r <= tx_ready;
        prev_b <= tx_byte;
    end

    // Memory request scoreboard; write data only matters for writes.
    always @(negedge clk) begin
        logic [48:0] e;
        if (!rst && mem_req && mem_ready) begin
            total++;
            assert (exp_req.size() > 0) else begin
                bad++;
                $error("FAIL mem_extra observed=%0h expected=none", {mem_we, mem_addr});
            end
            if (exp_req.size() > 0) begin
                e = exp_req.pop_front();
                check("req_we", 64'(mem_we), 64'(e[48]));
                check("req_addr", 64'(mem_addr), 64'(e[47:32]));
                if (e[48])
                    check("req_wdata", 64'(mem_wdata), 64'(e[31:0]));
            end
        end
    end

    // Memory model: read data returns two cycles after acceptance.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && mem_req && mem_ready && !mem_we) begin
                repeat (2) @(posedge clk);
                #1 mem_rvalid = 1'b1;
                mem_rdata = rd_value;
                @(posedge clk);
                #1 mem_rvalid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1 rx_byte = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i]);
            x = x ^ frame[i];
        end
`ifdef UART_MEM_BRIDGE_CKSUM_EN
        send_byte(x ^ ck_corrupt);
`endif
    endtask

    task automatic exp_single(input logic [7:0] b);
        exp_tx.push_back(b);
`ifdef UART_MEM_BRIDGE_CKSUM_EN
        exp_tx.push_back(b);
`endif
    endtask

    task automatic exp_read(input logic [31:0] d);
        exp_tx.push_back(d[31:24]);
        exp_tx.push_back(d[23:16]);
        exp_tx.push_back(d[15:8]);
        exp_tx.push_back(d[7:0]);
`ifdef UART_MEM_BRIDGE_CKSUM_EN
        exp_tx.push_back(d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0]);
`endif
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_tx_valid(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_valid) break;
        end
        check(tag, 64'(tx_valid), 64'd1);
    endtask

    initial begin
        int nbytes;
        rst        = 1'b1;
        rx_byte    = 8'h00;
        rx_valid   = 1'b0;
        tx_ready   = 1'b1;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        sts_clr    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {tx_valid, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, status, busy}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Write with latency checks.
        exp_req.push_back({1'b1, 16'h0010, 32'hDEADBEEF});
        exp_single(8'h4B);
        frame = '{8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame();
        @(negedge clk);
        check("wr_req_lat", 64'(mem_req), 64'd1);
        @(negedge clk);
        check("wr_tx_lat", 64'(tx_valid), 64'd1);
        wait_idle("wr_idle");
        check("wr_status", 64'(status), 64'h1);

        // Read; first response byte the cycle after rvalid.
        rd_value = 32'h12345678;
        exp_req.push_back({1'b0, 16'h0020, 32'h0});
        exp_read(32'h12345678);
        frame = '{8'h52, 8'h00, 8'h20};
        send_frame();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_rvalid) break;
        end
        check("rd_rvalid_seen", 64'(mem_rvalid), 64'd1);
        @(negedge clk);
        check("rd_tx_lat", 64'(tx_valid), 64'd1);
        wait_idle("rd_idle");

        // Bad opcode, then clear.
        exp_single(8'h3F);
        send_byte(8'h41);
        wait_idle("bad_idle");
        check("bad_status", 64'(status), 64'h3);
        @(posedge clk);
        #1 sts_clr = 1'b1;
        @(posedge clk);
        #1 sts_clr = 1'b0;
        @(negedge clk);
        check("clr_status", 64'(status), 64'h0);

        // Timeout after a partial frame, then a normal read.
        send_byte(8'h57);
        send_byte(8'h00);
        repeat (10) @(negedge clk);
        check("tmo_busy_mid", 64'(busy), 64'd1);
        check("tmo_status_mid", 64'(status), 64'h0);
        repeat (10) @(negedge clk);
        check("tmo_busy_end", 64'(busy), 64'd0);
        check("tmo_status", 64'(status), 64'h4);
        rd_value = 32'hCAFEF00D;
        exp_req.push_back({1'b0, 16'h0030, 32'h0});
        exp_read(32'hCAFEF00D);
        frame = '{8'h52, 8'h00, 8'h30};
        send_frame();
        wait_idle("tmo_rd_idle");
        check("tmo_rd_status", 64'(status), 64'h5);

        // Backpressure with an RX byte arriving during RESP.
        rd_value = 32'hA1B2C3D4;
        exp_req.push_back({1'b0, 16'h0044, 32'h0});
        exp_read(32'hA1B2C3D4);
        nbytes = exp_tx.size();
        tx_ready = 1'b0;
        frame = '{8'h52, 8'h00, 8'h44};
        send_frame();
        for (int k = 0; k < nbytes; k++) begin
            wait_tx_valid("bp_valid");
            if (k == 0) begin
                send_byte(8'h55);
                repeat (3) @(posedge clk);
            end else begin
                repeat (5) @(posedge clk);
            end
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        tx_ready = 1'b1;
        wait_idle("bp_idle");
        check("ovr_status", 64'(status[3]), 64'd1);

        // mem_ready stall keeps the request stable.
        mem_ready = 1'b0;
        exp_req.push_back({1'b1, 16'h0050, 32'h11223344});
        exp_single(8'h4B);
        frame = '{8'h57, 8'h00, 8'h50, 8'h11, 8'h22, 8'h33, 8'h44};
        send_frame();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req", 64'(mem_req), 64'd1);
            check("stall_addr", 64'(mem_addr), 64'h0050);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        wait_idle("stall_idle");

        // Reset while mem_req is high drops it without a clock edge.
        mem_ready = 1'b0;
        frame = '{8'h57, 8'h00, 8'h60, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame();
        @(negedge clk);
        check("pre_rst_req", 64'(mem_req), 64'd1);
        #1 rst = 1'b1;
        #1 check("async_req_drop", {mem_req, busy}, 64'd0);
        repeat (2) @(posedge clk);
        mem_ready = 1'b1;
        #1 rst = 1'b0;

        // Reset mid-frame, then a full frame executes.
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h10);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("midframe_rst_outs",
                 {tx_valid, tx_byte, mem_req, mem_we, mem_addr, mem_wdata, status, busy}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_req.push_back({1'b1, 16'h0042, 32'h0BADF00D});
        exp_single(8'h4B);
        frame = '{8'h57, 8'h00, 8'h42, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
        send_frame();
        wait_idle("post_rst_idle");
        check("post_rst_status", 64'(status), 64'h1);

`ifdef UART_MEM_BRIDGE_CKSUM_EN
        // Corrupted checksum: no memory access, 'E' plus its checksum.
        exp_tx.push_back(8'h45);
        exp_tx.push_back(8'h45);
        ck_corrupt = 8'hFF;
        frame = '{8'h57, 8'h00, 8'h70, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame();
        ck_corrupt = 8'h00;
        wait_idle("ck_idle");
        check("ck_status", 64'(status), 64'h3);
`endif

        repeat (4) @(negedge clk);
        check("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
        check("req_queue_empty", 64'(exp_req.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

- Parametrised UART command engine that turns a received byte stream into single-word memory reads and writes, and returns a response byte stream.
- Sits between the UART RX/TX byte layer (driven by the baud tick generators) and a memory/register port.
- Replaces ad-hoc sticky LED status with a clearable status vector.
- Adds a programmable inter-byte frame timeout.

## Interface
Parameters:
- ADDR_BYTES, 2, address field length in bytes (1-4); mem_addr width = 8*ADDR_BYTES
- DATA_BYTES, 4, data word length in bytes (1-4); mem_wdata/mem_rdata width = 8*DATA_BYTES
- TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes of one frame; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_byte  in  8  received byte, valid with rx_valid
- rx_valid  in  1  single-cycle pulse per received byte
- tx_byte  out  8  response byte
- tx_valid  out  1  response byte valid; held until tx_ready
- tx_ready  in  1  TX layer accepts tx_byte this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  8*ADDR_BYTES  request address
- mem_wdata  out  8*DATA_BYTES  write data
- mem_ready  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid; at least 1 cycle after acceptance
- mem_rdata  in  8*DATA_BYTES  read data
- sts_clr  in  1  synchronous clear of all sticky status bits
- status  out  4  sticky flags: [0] frame completed, [1] bad opcode/checksum, [2] timeout, [3] RX overrun
- busy  out  1  high whenever the state is not IDLE

## Operation
- Frame format (all multi-byte fields MSB first):
  - opcode 0x57 'W' + ADDR_BYTES address + DATA_BYTES data
  - opcode 0x52 'R' + ADDR_BYTES address
- States: IDLE, ADDR, DATA, CKSUM (macro only), MEM_REQ, MEM_WAIT, RESP.
- IDLE: a valid opcode goes to ADDR. Any other byte sets status[1] and queues the single response 0x3F '?', then RESP.
- ADDR/DATA: bytes shift into the address/data registers, with a field byte counter. After the last field byte:
  - 'W' with no address bytes left: DATA.
  - 'R', or DATA complete: MEM_REQ (or CKSUM if the macro is defined).
- MEM_REQ:
  - mem_req=1 with mem_we/mem_addr/mem_wdata stable until the mem_ready cycle.
  - Write then goes to RESP with response 0x4B 'K'.
  - Read goes to MEM_WAIT.
- MEM_WAIT: on mem_rvalid, capture mem_rdata, then RESP with DATA_BYTES bytes.
- RESP:
  - Present bytes in order; advance only on tx_valid&tx_ready.
  - After the last byte: set status[0] (except after '?'), then IDLE.
- rx_valid in MEM_REQ/MEM_WAIT/RESP: byte dropped, status[3] set.
- Timeout: in ADDR/DATA/CKSUM, a counter clears on each rx_valid and increments otherwise. Reaching TIMEOUT_CYCLES:
  - return to IDLE next cycle;
  - set status[2];
  - discard the partial frame;
  - send no response.
- Counter width: $clog2(TIMEOUT_CYCLES+1).
- sts_clr and a status set in the same cycle: set wins.

## Timing
- Reset values:
  - tx_valid=0, tx_byte=0x00
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - status=0, busy=0
  - state IDLE, counters 0
- Last frame byte at cycle N: mem_req=1 at N+1. If mem_ready is high at N+1, write response tx_valid=1 at N+2.
- Read response: first tx_valid one cycle after the mem_rvalid cycle.
- Consecutive response bytes: the next byte is valid the cycle after the handshake. No bubble is required; no byte repeats.
- Reset mid-frame or mid-transfer: immediate abort. mem_req and tx_valid drop asynchronously.
- Maximum frame length: 1+ADDR_BYTES+DATA_BYTES (+1 checksum) bytes. Field counters must not wrap.

## Configuration
- UART_MEM_BRIDGE_CKSUM_EN defined:
  - Frames carry a trailing checksum byte = XOR of all preceding frame bytes.
  - On mismatch: no memory access, status[1] set, response 0x45 'E'.
  - Responses 'K'/'?'/'E' are followed by an XOR checksum byte; read data is followed by the XOR of the data bytes.
- UART_MEM_BRIDGE_CKSUM_EN undefined: no CKSUM state and no checksum bytes; frames end at the last address/data byte.

## Structure
- Package uart_mem_pkg holds:
  - opcode constants (0x57, 0x52);
  - response constants (0x4B, 0x3F, 0x45);
  - the state enum;
  - status bit index localparams.
- Sub-module uart_frame_timer holds the parametrised timeout counter. Inputs: clear, enable. Output: expire pulse. With TIMEOUT_CYCLES=0, expire is tied to 0.

## Test plan
- Write: RX 57 00 10 DE AD BE EF, mem_ready=1 -> one request with mem_we=1, addr 0x0010, wdata 0xDEADBEEF; TX 4B; status[0]=1.
- Read: RX 52 00 20; mem_rvalid 2 cycles after accept with rdata 0x12345678 -> TX 12 34 56 78; busy low afterwards.
- Bad opcode: RX 41 -> TX 3F, status[1]=1, no mem_req. Then sts_clr -> status=0.
- Timeout: with TIMEOUT_CYCLES=16, RX 57 00 then silence -> IDLE after 16 cycles, status[2]=1, no TX. A subsequent valid read completes normally.
- Backpressure/overrun:
  - tx_ready low 5 cycles per byte during a read response -> bytes stable and in order.
  - An RX byte during RESP -> status[3]=1, response unchanged.
- Reset mid-frame (after 57 00 10) -> all outputs at reset values. The next full frame executes. With the macro: a wrong checksum gives TX 45 45.
